uart_tx_buffer: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_tx_buffer.sv | 92 +++++++++
 tb/tb_uart_tx_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART transmit buffer
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int STATS_WIDTH    = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock byte FIFO with registered read data and occupancy flags
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    // Writes use the current full flag, so a write while full is dropped even
    // if a read frees a slot on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Extra pointer MSB tells a full ring apart from an empty one.
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte queue and issue sequencer ahead of the UART serializer; optional UART_TX_BUF_STATS_EN adds a drop counter
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_WIDTH:0]    level,
    output logic                   tx_start,
    output logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   tx_done,
`ifdef UART_TX_BUF_STATS_EN
    output logic [STATS_WIDTH-1:0] overflow_cnt,
    input  logic                   clr_stats,
`endif
    output logic                   busy
);

    tx_state_t state;
    tx_state_t state_nxt;
    logic      pop;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (tx_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_start <= pop;
        end
    end

    // A tx_done coinciding with our own tx_start cannot belong to that character.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done && !tx_start) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_WAIT);

`ifdef UART_TX_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (clr_stats) begin
            overflow_cnt <= '0;
        end else if (wr_en && full && (overflow_cnt != {STATS_WIDTH{1'b1}})) begin
            overflow_cnt <= overflow_cnt + STATS_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - directed self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          tx_done = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          busy;
`ifdef UART_TX_BUF_STATS_EN
    logic          clr_stats = 1'b0;
    logic [7:0]    overflow_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
`ifdef UART_TX_BUF_STATS_EN
        .overflow_cnt (overflow_cnt),
        .clr_stats    (clr_stats),
`endif
        .busy         (busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if ({tx_start, busy, full, empty} !== 4'b0001) begin bad++; $display("FAIL reset_flags got=%b exp=0001", {tx_start, busy, full, empty}); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
`ifdef UART_TX_BUF_STATS_EN
        total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst();
        logic [7:0] bytes_q [4] = '{8'h41, 8'h55, 8'h66, 8'h7A};
        int idx = 0;
        int expect_at = 2;
        int done_c = -1;
        int c = 0;
        bit fin = 1'b0;
        wr_en = 1'b1; wr_data = bytes_q[0];
        while (!fin && c < 400) begin
            @(negedge clk);
            c++;
            if (c < 4) begin wr_en = 1'b1; wr_data = bytes_q[c]; end
            else wr_en = 1'b0;
            tx_done = 1'b0;
            if (tx_start) begin
                if (idx > 3) begin
                    total++; bad++; $display("FAIL burst_extra_start cycle=%0d data=%h", c, tx_data);
                end else begin
                    total++; if (tx_data !== bytes_q[idx]) begin bad++; $display("FAIL burst_data[%0d] got=%h exp=%h", idx, tx_data, bytes_q[idx]); end
                    total++; if (c !== expect_at) begin bad++; $display("FAIL burst_timing[%0d] got=%0d exp=%0d", idx, c, expect_at); end
                    idx++;
                    done_c = c + 20;
                end
            end
            if (c == done_c) begin
                tx_done = 1'b1;
                expect_at = c + 1;
            end
            if (idx == 4 && done_c > 0 && c == done_c + 2) fin = 1'b1;
        end
        tx_done = 1'b0;
        total++; if (!fin) begin bad++; $display("FAIL burst_timeout got=%0d starts exp=4", idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_overflow();
        tx_done = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
            if (i == 15) begin
                total++; if ({full, level} !== {1'b0, 5'd15}) begin bad++; $display("FAIL ovf_pre_full got=full%b/lvl%0d exp=full0/lvl15", full, level); end
            end
            if (i == 16) begin
                total++; if ({full, level} !== {1'b1, 5'd16}) begin bad++; $display("FAIL ovf_full got=full%b/lvl%0d exp=full1/lvl16", full, level); end
            end
        end
        wr_data = 8'h12;
        @(negedge clk);
        wr_en = 1'b0;
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level_hold got=%0d exp=16", level); end
        total++; if ({busy, tx_data} !== {1'b1, 8'h00}) begin bad++; $display("FAIL ovf_first_issue got=busy%b/%h exp=busy1/00", busy, tx_data); end
`ifdef UART_TX_BUF_STATS_EN
        total++; if (overflow_cnt !== 8'd2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", overflow_cnt); end
`endif
        for (int k = 1; k <= 16; k++) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            total++; if ({tx_start, tx_data} !== {1'b1, 8'(k)}) begin bad++; $display("FAIL ovf_drain[%0d] got=start%b/%h exp=start1/%h", k, tx_start, tx_data, 8'(k)); end
            @(negedge clk);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if ({tx_start, busy, empty} !== 3'b001) begin bad++; $display("FAIL ovf_drain_end got=%b exp=001", {tx_start, busy, empty}); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        total++; if (level !== 5'd5) begin bad++; $display("FAIL simul_setup_level got=%0d exp=5", level); end
        wr_en = 1'b1; wr_data = 8'hA6; tx_done = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; tx_done = 1'b0;
        total++; if (level !== 5'd5) begin bad++; $display("FAIL simul_level got=%0d exp=5", level); end
        total++; if ({tx_start, tx_data} !== {1'b1, 8'hA1}) begin bad++; $display("FAIL simul_pop got=start%b/%h exp=start1/a1", tx_start, tx_data); end
        @(negedge clk);
        for (int k = 2; k <= 6; k++) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            total++; if ({tx_start, tx_data} !== {1'b1, 8'hA0 + 8'(k)}) begin bad++; $display("FAIL simul_order[%0d] got=start%b/%h exp=start1/%h", k, tx_start, tx_data, 8'hA0 + 8'(k)); end
            @(negedge clk);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if ({busy, empty} !== 2'b01) begin bad++; $display("FAIL simul_end got=%b exp=01", {busy, empty}); end
        @(negedge clk);
    endtask

    task automatic test_ignored_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if ({tx_start, busy, level} !== {2'b00, 5'd0}) begin bad++; $display("FAIL idle_done got=start%b/busy%b/lvl%0d exp=0/0/0", tx_start, busy, level); end
        wr_en = 1'b1; wr_data = 8'hB0;
        @(negedge clk);
        wr_data = 8'hB1;
        @(negedge clk);
        wr_en = 1'b0;
        total++; if ({tx_start, tx_data} !== {1'b1, 8'hB0}) begin bad++; $display("FAIL ign_first got=start%b/%h exp=start1/b0", tx_start, tx_data); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if ({tx_start, busy, level, tx_data} !== {2'b01, 5'd1, 8'hB0}) begin bad++; $display("FAIL ign_coincident got=start%b/busy%b/lvl%0d/%h exp=0/1/1/b0", tx_start, busy, level, tx_data); end
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if ({tx_start, tx_data, level} !== {1'b1, 8'hB1, 5'd0}) begin bad++; $display("FAIL ign_second got=start%b/%h/lvl%0d exp=1/b1/0", tx_start, tx_data, level); end
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_end_busy got=%b exp=0", busy); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        total++; if ({busy, level} !== {1'b1, 5'd3}) begin bad++; $display("FAIL arst_setup got=busy%b/lvl%0d exp=busy1/lvl3", busy, level); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({tx_start, busy, full, empty, level, tx_data} !== {4'b0001, 5'd0, 8'h00}) begin bad++; $display("FAIL arst_immediate got=%b/lvl%0d/%h exp=0001/lvl0/00", {tx_start, busy, full, empty}, level, tx_data); end
`ifdef UART_TX_BUF_STATS_EN
        total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL arst_ovf got=%0d exp=0", overflow_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || level !== 5'd0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL arst_quiet got=activity exp=none"); end
        wr_en = 1'b1; wr_data = 8'hD5;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        total++; if ({tx_start, tx_data} !== {1'b1, 8'hD5}) begin bad++; $display("FAIL arst_restart got=start%b/%h exp=start1/d5", tx_start, tx_data); end
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
    endtask

`ifdef UART_TX_BUF_STATS_EN
    task automatic test_stats();
        wr_en = 1'b1; wr_data = 8'hEE;
        for (int i = 0; i < 17; i++) @(negedge clk);
        total++; if ({full, overflow_cnt} !== {1'b1, 8'd0}) begin bad++; $display("FAIL stats_fill got=full%b/cnt%0d exp=full1/cnt0", full, overflow_cnt); end
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (j == 253) begin
                total++; if (overflow_cnt !== 8'd254) begin bad++; $display("FAIL stats_254 got=%0d exp=254", overflow_cnt); end
            end
        end
        total++; if (overflow_cnt !== 8'd255) begin bad++; $display("FAIL stats_sat got=%0d exp=255", overflow_cnt); end
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0; wr_en = 1'b0;
        total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL stats_clr got=%0d exp=0", overflow_cnt); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_overflow();
        test_simultaneous();
        test_ignored_done();
        test_async_reset();
`ifdef UART_TX_BUF_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
